// File: rtl/quad_decoder.sv
// Quadrature encoder front end: two-flop synchroniser, per-phase debounce,
// 4x decode into a position counter with step strobe, direction and a
// sticky illegal-transition flag.
//
// state | meaning
// ------+----------------------------------------------------------------
// ACQ   | after reset: filters and prev track the pins directly, no decode
// RUN   | debounce active, transitions decoded into count/step/dir/err
module quad_decoder #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             enable,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    input  logic             err_clr,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             err
);

    typedef enum logic {
        ACQ = 1'b0,
        RUN = 1'b1
    } state_t;

    // ACQ spans DEBOUNCE+2 cycles; 9 bits because DEBOUNCE may reach 255.
    localparam logic [8:0]       ACQ_LOAD = 9'(DEBOUNCE + 1);
    localparam logic [7:0]       DB_LAST  = 8'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] VMAX     = {WIDTH{1'b1}};

    state_t           state;
    state_t           state_nxt;
    logic [8:0]       acq_cnt;

    // Bit 1 is phase A, bit 0 is phase B throughout.
    logic [1:0]       sync_1;
    logic [1:0]       sync_ab;
    logic [1:0]       filt;
    logic [1:0]       prev;
    logic [7:0]       db_cnt [0:1];

    logic             fwd;
    logic             rev;
    logic             ill;
    logic [WIDTH-1:0] value_up;
    logic [WIDTH-1:0] value_dn;

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ACQ;
        end else begin
            state <= state_nxt;
        end
    end

    // Acquisition down-counter; leaving ACQ happens at terminal count zero.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            acq_cnt <= ACQ_LOAD;
        end else if (state == ACQ && acq_cnt != 9'd0) begin
            acq_cnt <= acq_cnt - 9'd1;
        end
    end

    // Next state and transition classification of prev -> filt.
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        rev       = 1'b0;
        ill       = 1'b0;
        case (state)
            ACQ: begin
                if (acq_cnt == 9'd0) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                case ({prev, filt})
                    4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
                    4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: rev = 1'b1;
                    4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: ill = 1'b1;
                    default: ;
                endcase
            end
            default: state_nxt = ACQ;
        endcase
    end

    // Candidate next counts; saturating build clamps at the rails.
    always_comb begin
        value_up = value + WIDTH'(1);
        value_dn = value - WIDTH'(1);
        if (SATURATE && value == VMAX) begin
            value_up = value;
        end
        if (SATURATE && value == '0) begin
            value_dn = value;
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_1  <= 2'b00;
            sync_ab <= 2'b00;
        end else begin
            sync_1  <= {enc_a, enc_b};
            sync_ab <= sync_1;
        end
    end

    // Per-phase debounce into filt; ACQ copies straight through so the
    // levels present at reset release never look like a transition.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            filt      <= 2'b00;
            prev      <= 2'b00;
            db_cnt[0] <= 8'd0;
            db_cnt[1] <= 8'd0;
        end else if (state == ACQ) begin
            filt      <= sync_ab;
            prev      <= filt;
            db_cnt[0] <= 8'd0;
            db_cnt[1] <= 8'd0;
        end else begin
            prev <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_ab[i] == filt[i]) begin
                    db_cnt[i] <= 8'd0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync_ab[i];
                    db_cnt[i] <= 8'd0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    // Output registers: count, step strobe, direction and sticky error.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            value <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            err   <= 1'b0;
        end else begin
            step <= 1'b0;
            if (enable && (fwd || rev)) begin
                step <= 1'b1;
                dir  <= fwd;
            end
            if (clear) begin
                value <= '0;
            end else if (enable && fwd) begin
                value <= value_up;
            end else if (enable && rev) begin
                value <= value_dn;
            end
            if (ill) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed and randomized checks of quad_decoder, wrapping and saturating
// builds side by side, against a phase-index reference model.
module tb_quad_decoder;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int MAXV = (1 << W) - 1;
    localparam int LAT  = D + 3;
    localparam logic [1:0] SEQ [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         enable  = 1'b1;
    logic         enc_a   = 1'b0;
    logic         enc_b   = 1'b0;
    logic         clear   = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] value_w, value_s;
    logic         step_w, step_s, dir_w, dir_s, err_w, err_s;

    int n_checks = 0;
    int n_pass   = 0;
    int steps_w  = 0;
    int steps_s  = 0;

    int         mv_w, mv_s, exp_steps;
    logic       mdir, merr;
    logic [1:0] mpins;

    quad_decoder #(.WIDTH(W), .DEBOUNCE(D), .SATURATE(1'b0)) u_wrap (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .enc_a(enc_a),
        .enc_b(enc_b), .clear(clear), .err_clr(err_clr), .value(value_w),
        .step(step_w), .dir(dir_w), .err(err_w)
    );

    quad_decoder #(.WIDTH(W), .DEBOUNCE(D), .SATURATE(1'b1)) u_sat (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .enc_a(enc_a),
        .enc_b(enc_b), .clear(clear), .err_clr(err_clr), .value(value_s),
        .step(step_s), .dir(dir_s), .err(err_s)
    );

    always #5 clk = ~clk;

    // Step pulses are tallied on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (step_w) steps_w++;
        if (step_s) steps_s++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int phase_of(input logic [1:0] p);
        for (int i = 0; i < 4; i++) begin
            if (SEQ[i] == p) return i;
        end
        return 0;
    endfunction

    // Expected effect of the pins settling on np, judged by quarter-turn distance.
    task automatic model_move(input logic [1:0] np, input logic en);
        int d;
        d = (phase_of(np) - phase_of(mpins) + 4) % 4;
        if (d == 2) begin
            merr = 1'b1;
        end else if (d == 1 && en) begin
            mv_w = (mv_w + 1) % (MAXV + 1);
            mv_s = (mv_s < MAXV) ? mv_s + 1 : mv_s;
            mdir = 1'b1;
            exp_steps++;
        end else if (d == 3 && en) begin
            mv_w = (mv_w + MAXV) % (MAXV + 1);
            mv_s = (mv_s > 0) ? mv_s - 1 : 0;
            mdir = 1'b0;
            exp_steps++;
        end
        mpins = np;
    endtask

    task automatic move(input logic [1:0] np, input int hold);
        model_move(np, enable);
        {enc_a, enc_b} = np;
        tick(hold);
    endtask

    task automatic model_reset();
        mv_w  = 0;
        mv_s  = 0;
        mdir  = 1'b0;
        merr  = 1'b0;
        mpins = {enc_a, enc_b};
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value_w"}, 32'(value_w), 32'(mv_w));
        check({tag, ".value_s"}, 32'(value_s), 32'(mv_s));
        check({tag, ".dir"},     32'(dir_w),   32'(mdir));
        check({tag, ".dir_s"},   32'(dir_s),   32'(mdir));
        check({tag, ".err"},     32'(err_w),   32'(merr));
        check({tag, ".err_s"},   32'(err_s),   32'(merr));
        check({tag, ".steps_w"}, 32'(steps_w), 32'(exp_steps));
        check({tag, ".steps_s"}, 32'(steps_s), 32'(exp_steps));
    endtask

    initial begin
        logic [1:0] np;
        int         kind;
        int         ph;
        int         len;
        int         pin;

        exp_steps = 0;

        // Reset with both pins high, then acquisition must not count.
        {enc_a, enc_b} = 2'b11;
        rst = 1'b1;
        tick(3);
        check("rst.value", 32'(value_w), 32'd0);
        check("rst.step",  32'(step_w),  32'd0);
        check("rst.dir",   32'(dir_w),   32'd0);
        check("rst.err",   32'(err_w),   32'd0);
        rst = 1'b0;
        model_reset();
        tick(20);
        check_all("acq11");

        // Restart from 00 for the directed sequence.
        {enc_a, enc_b} = 2'b00;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(20);

        // Forward cycle; first transition also checks latency.
        model_move(2'b10, enable);
        {enc_a, enc_b} = 2'b10;
        tick(LAT - 1);
        check("lat.before", 32'(step_w), 32'd0);
        tick(1);
        check("lat.at",     32'(step_w),  32'd1);
        check("lat.value",  32'(value_w), 32'd1);
        tick(10 - LAT);
        move(2'b11, 10);
        move(2'b01, 10);
        move(2'b00, 10);
        check_all("fwd");
        check("fwd.lit", 32'(value_w), 32'd4);

        // Zero the count, then a full reverse cycle.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        mv_w = 0;
        mv_s = 0;
        tick(2);
        check_all("clr");
        move(2'b01, 10);
        move(2'b11, 10);
        move(2'b10, 10);
        move(2'b00, 10);
        check_all("rev");
        check("rev.lit_w", 32'(value_w), 32'd252);
        check("rev.lit_s", 32'(value_s), 32'd0);

        // Glitch one cycle shorter than the debounce window is ignored.
        enc_a = 1'b1;
        tick(D - 1);
        enc_a = 1'b0;
        tick(12);
        check_all("glitch");

        // A pulse exactly DEBOUNCE long is accepted, and so is its return.
        enc_a = 1'b1;
        tick(D);
        enc_a = 1'b0;
        tick(4);
        model_move(2'b10, 1'b1);
        check_all("pulse.up");
        tick(8);
        model_move(2'b00, 1'b1);
        check_all("pulse.dn");

        // Illegal jump, lone err_clr, then err_clr racing a second jump.
        move(2'b11, 10);
        check_all("ill1");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        merr = 1'b0;
        tick(1);
        check("errclr", 32'(err_w), 32'd0);
        model_move(2'b00, enable);
        {enc_a, enc_b} = 2'b00;
        tick(LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("errclr.setwins", 32'(err_w), 32'd1);
        tick(3);
        check_all("ill2");

        // clear landing on the same edge as a forward transition.
        model_move(2'b10, enable);
        {enc_a, enc_b} = 2'b10;
        tick(LAT - 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        mv_w = 0;
        mv_s = 0;
        check("clrcoin.value", 32'(value_w), 32'd0);
        check("clrcoin.step",  32'(step_w),  32'd1);
        check("clrcoin.dir",   32'(dir_w),   32'd1);
        tick(3);
        check_all("clrcoin");

        // Disabled transitions leave no trace after re-enable.
        move(2'b11, 10);
        enable = 1'b0;
        move(2'b01, 10);
        move(2'b00, 10);
        move(2'b10, 10);
        check_all("dis");
        enable = 1'b1;
        tick(10);
        check_all("reen");

        // Randomized walk: forward/reverse/illegal/glitch with random controls.
        for (int it = 0; it < 40; it++) begin
            kind   = $urandom_range(0, 5);
            enable = ($urandom_range(0, 3) != 0);
            ph     = phase_of(mpins);
            if (kind == 5) begin
                pin = $urandom_range(0, 1);
                len = $urandom_range(1, D - 1);
                if (pin == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
                tick(len);
                if (pin == 1) enc_a = ~enc_a; else enc_b = ~enc_b;
                tick(12);
            end else begin
                if (kind < 2)       np = SEQ[(ph + 1) % 4];
                else if (kind < 4)  np = SEQ[(ph + 3) % 4];
                else                np = SEQ[(ph + 2) % 4];
                move(np, 10);
                if ($urandom_range(0, 5) == 0) begin
                    clear = 1'b1;
                    tick(1);
                    clear = 1'b0;
                    mv_w = 0;
                    mv_s = 0;
                end
                if ($urandom_range(0, 3) == 0) begin
                    err_clr = 1'b1;
                    tick(1);
                    err_clr = 1'b0;
                    merr = 1'b0;
                end
                tick(1);
            end
            check_all("rnd");
        end

        // Reset while a transition is still inside the debounce window.
        enable = 1'b1;
        ph = phase_of(mpins);
        {enc_a, enc_b} = SEQ[(ph + 1) % 4];
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(15);
        check_all("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
